irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 113 +++++++++++
 tb/tb_irq_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: 16-source interrupt controller with edge/level modes,
// per-source mask, global enable and a lowest-index vector register.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   stb, we       bus strobe and write enable (ack = stb)
//   addr          0 PEND (W1C), 1 MASK, 2 MODE, 3 CTRL/VEC
//   data_in       bus write data
//   data_out      bus read data (combinational)
//   ack           bus acknowledge
//   irq_in        interrupt sources (bit 0 = timer)
//   irq           registered request to the CPU
module irq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic [15:0] irq_in,
    output logic        irq
);

    logic [15:0] pending;
    logic [15:0] mask;
    logic [15:0] mode;
    logic [15:0] prev;
    logic        gie;
    logic        vvalid;
    logic [3:0]  vnum;

    logic        wr_en;
    logic [15:0] w1c;
    logic [15:0] rise;
    logic [15:0] pend_nxt;
    logic [15:0] active;
    logic [3:0]  vnum_nxt;
    logic [31:0] rd_mux;
    logic        unused_hi;

    assign unused_hi = ^data_in[31:16];

    assign ack   = stb;
    assign wr_en = stb & we;

    assign w1c = (wr_en && addr == 2'd0)
               ? data_in[15:0] : 16'h0000;

    assign rise = irq_in & ~prev;

    // Edge sources: a new rising edge wins over a W1C in
    // the same cycle. Level sources simply track irq_in.
    assign pend_nxt =
        (mode & (rise | (pending & ~w1c))) |
        (~mode & irq_in);

    assign active = pending & mask;

    // Downward scan so the lowest set index is the last
    // assignment and therefore wins.
    always_comb begin
        vnum_nxt = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) begin
                vnum_nxt = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 16'h0000;
            mask    <= 16'h0000;
            mode    <= 16'h0000;
            prev    <= 16'h0000;
            gie     <= 1'b0;
            vnum    <= 4'd0;
            vvalid  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            prev    <= irq_in;
            pending <= pend_nxt;
            vnum    <= vnum_nxt;
            vvalid  <= |active;
            irq     <= gie & (|active);
            if (wr_en && addr == 2'd1) begin
                mask <= data_in[15:0];
            end
            if (wr_en && addr == 2'd2) begin
                mode <= data_in[15:0];
            end
            if (wr_en && addr == 2'd3) begin
                gie <= data_in[0];
            end
        end
    end

    always_comb begin
        rd_mux = 32'h0000_0000;
        unique case (addr)
            2'd0: rd_mux = {16'h0000, pending};
            2'd1: rd_mux = {16'h0000, mask};
            2'd2: rd_mux = {16'h0000, mode};
            2'd3: rd_mux = {vvalid, 22'd0, gie,
                            4'd0, vnum};
            default: rd_mux = 32'h0000_0000;
        endcase
    end

    assign data_out = stb ? rd_mux : 32'h0000_0000;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed stimulus with a queued scoreboard;
// a negedge monitor pops expectations as reads/irq checks occur.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic [15:0] irq_in;
    logic        irq;

    typedef struct {
        logic [31:0] v;
        string       n;
    } exp_t;

    exp_t dq[$];
    exp_t iq[$];
    logic ichk;
    int   total;
    int   bad;

    irq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .irq_in   (irq_in),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t e;
        total++;
        if (ack !== stb) begin
            bad++;
            $display("FAIL ack: act=%b req=%b", ack, stb);
        end
        if (stb && !we) begin
            total++;
            if (dq.size() == 0) begin
                bad++;
                $display("FAIL dq_empty: act=read req=none");
            end else begin
                e = dq.pop_front();
                if (data_out !== e.v) begin
                    bad++;
                    $display("FAIL %s: act=%h req=%h",
                             e.n, data_out, e.v);
                end
            end
        end
        if (ichk) begin
            total++;
            if (iq.size() == 0) begin
                bad++;
                $display("FAIL iq_empty: act=chk req=none");
            end else begin
                e = iq.pop_front();
                if (irq !== e.v[0]) begin
                    bad++;
                    $display("FAIL %s: act=%b req=%b",
                             e.n, irq, e.v[0]);
                end
            end
        end
    end

    task automatic push_irq(input bit ei,
                            input string nm);
        exp_t e;
        e.v = {31'd0, ei};
        e.n = nm;
        iq.push_back(e);
        ichk = 1'b1;
    endtask

    task automatic step(input bit ck = 0,
                        input bit ei = 0,
                        input string nm = "irq");
        if (ck) push_irq(ei, nm);
        @(posedge clk);
        #1;
        ichk = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a,
                      input logic [31:0] ev,
                      input string nm,
                      input bit ck = 0,
                      input bit ei = 0);
        exp_t e;
        e.v = ev;
        e.n = nm;
        dq.push_back(e);
        if (ck) push_irq(ei, {nm, "_irq"});
        stb  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        stb  = 1'b0;
        ichk = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a,
                      input logic [31:0] d);
        stb     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        stb     = 1'b0;
        we      = 1'b0;
        data_in = 32'h0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ichk    = 1'b0;
        rst     = 1'b1;
        stb     = 1'b0;
        we      = 1'b0;
        addr    = 2'd0;
        data_in = 32'h0;
        irq_in  = 16'h0;
        step();
        step();
        rst = 1'b0;

        // reset state
        rd(0, 32'h0, "rst_pend", 1, 0);
        rd(1, 32'h0, "rst_mask");
        rd(2, 32'h0, "rst_mode");
        rd(3, 32'h0, "rst_vec");

        // write with stb low is ignored
        we      = 1'b1;
        addr    = 2'd1;
        data_in = 32'hFFFF;
        step();
        we      = 1'b0;
        data_in = 32'h0;
        rd(1, 32'h0, "nostb_mask");

        // edge, clear, re-arm
        wr(2, 32'h1);
        wr(1, 32'h1);
        wr(3, 32'h1);
        rd(2, 32'h1, "mode_rb");
        irq_in = 16'h0001;
        step();
        irq_in = 16'h0000;
        rd(0, 32'h1, "e_pend", 1, 0);
        rd(3, 32'h8000_0100, "e_vec", 1, 1);
        wr(0, 32'h1);
        rd(0, 32'h0, "e_clr", 1, 1);
        step(1, 0, "e_irq_off");
        irq_in = 16'h0001;
        step();
        wr(0, 32'h1);
        step();
        rd(0, 32'h0, "hold_pend", 1, 0);
        rd(3, 32'h0000_0100, "hold_vec");
        irq_in = 16'h0000;
        step();

        // priority and masking
        wr(2, 32'hFFFF);
        wr(1, 32'hFFF0);
        irq_in = 16'h0028;
        step();
        irq_in = 16'h0000;
        step();
        rd(0, 32'h28, "pr_pend");
        rd(3, 32'h8000_0105, "pr_vec", 1, 1);
        wr(0, 32'h20);
        step();
        rd(0, 32'h08, "pr_pend2");
        rd(3, 32'h0000_0100, "pr_vec2", 1, 0);

        // level mode
        wr(0, 32'h08);
        wr(2, 32'h0);
        wr(1, 32'h4);
        irq_in = 16'h0004;
        step();
        step();
        rd(0, 32'h4, "lv_pend", 1, 1);
        wr(0, 32'h4);
        rd(0, 32'h4, "lv_w1c", 1, 1);
        irq_in = 16'h0000;
        step();
        rd(0, 32'h0, "lv_fall", 1, 1);
        step(1, 0, "lv_irq_off");

        // set wins over clear
        wr(2, 32'hFFFF);
        irq_in = 16'h0002;
        wr(0, 32'h2);
        rd(0, 32'h2, "race", 1, 0);
        irq_in = 16'h0000;
        wr(0, 32'h2);
        rd(0, 32'h0, "race_clr");

        // reset mid-operation
        irq_in = 16'h0002;
        step();
        irq_in = 16'h0000;
        wr(1, 32'h2);
        step();
        rd(3, 32'h8000_0101, "pre_rst", 1, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd(0, 32'h0, "mr_pend", 1, 0);
        rd(1, 32'h0, "mr_mask");
        rd(2, 32'h0, "mr_mode");
        rd(3, 32'h0, "mr_vec");
        irq_in = 16'h0001;
        step();
        step();
        rd(0, 32'h1, "mr_lvl", 1, 0);
        rd(3, 32'h0, "mr_vec2", 1, 0);
        irq_in = 16'h0000;
        step();

        if (dq.size() != 0 || iq.size() != 0) begin
            bad++;
            $display("FAIL leftover: act=%0d req=0",
                     dq.size() + iq.size());
        end
        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
